// File: rtl/e_stage_reg.sv
// e_stage_reg -- D/E pipeline register with hazard-driven stall generation.
//
// Captures the D-stage operands and decode results into the E stage every
// cycle. It raises stall when the instruction in D needs a register that the
// instruction in E or M cannot deliver in time (Tuse/Tnew), or when D holds a
// mult/div-class instruction while the MD unit is busy. A stalled cycle
// inserts a bubble into E and bumps a saturating bubble counter.
//
// Ports:
//   clk, reset        clock (rising edge), async active-low reset
//   D_*               decode-stage instruction, operands and hazard info
//   E_md_busy         multiply/divide unit busy (or starting this cycle)
//   M_gwa, M_tnew     destination / remaining Tnew of the instruction in M
//   stall             freeze PC and F/D, bubble E (combinational)
//   E_*               registered E-stage values
//   E_tnew_next       Tnew handed to M: max(E_tnew-1, 0)
//   E_valid           E holds a real instruction
//   bubble_cnt        saturating count of bubbles since reset
module e_stage_reg #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      D_pc,
  input  logic [31:0]      D_instr,
  input  logic [31:0]      D_rs_d,
  input  logic [31:0]      D_rt_d,
  input  logic [4:0]       D_rs,
  input  logic [4:0]       D_rt,
  input  logic [31:0]      D_imm,
  input  logic [4:0]       D_gwa,
  input  logic [1:0]       D_tnew,
  input  logic             D_rs_use,
  input  logic [1:0]       D_rs_tuse,
  input  logic             D_rt_use,
  input  logic [1:0]       D_rt_tuse,
  input  logic             D_is_md,
  input  logic             E_md_busy,
  input  logic [4:0]       M_gwa,
  input  logic [1:0]       M_tnew,
  output logic             stall,
  output logic [31:0]      E_pc,
  output logic [31:0]      E_instr,
  output logic [31:0]      E_rs_d,
  output logic [31:0]      E_rt_d,
  output logic [31:0]      E_imm,
  output logic [4:0]       E_gwa,
  output logic [1:0]       E_tnew,
  output logic [1:0]       E_tnew_next,
  output logic             E_valid,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs_d;
    logic [31:0] rt_d;
    logic [31:0] imm;
    logic [4:0]  gwa;
    logic [1:0]  tnew;
  } e_pay_t;

  e_pay_t           r_e;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;

  logic   w_stall_rs, w_stall_rt, w_stall_md, w_stall;
  e_pay_t w_d, w_bubble;

  // A source stalls only when its producer still needs more cycles than the
  // consumer can wait; otherwise forwarding downstream covers the match.
  assign w_stall_rs = D_rs_use && (D_rs != 5'd0) &&
                      ((r_e.gwa == D_rs && r_e.tnew > D_rs_tuse) ||
                       (M_gwa   == D_rs && M_tnew   > D_rs_tuse));
  assign w_stall_rt = D_rt_use && (D_rt != 5'd0) &&
                      ((r_e.gwa == D_rt && r_e.tnew > D_rt_tuse) ||
                       (M_gwa   == D_rt && M_tnew   > D_rt_tuse));
  assign w_stall_md = D_is_md && E_md_busy;

  // Held low while in reset so upstream never freezes on stale E state.
  assign w_stall = reset && (w_stall_rs || w_stall_rt || w_stall_md);

  assign w_d = '{pc: D_pc, instr: D_instr, rs_d: D_rs_d, rt_d: D_rt_d,
                 imm: D_imm, gwa: D_gwa, tnew: D_tnew};

  // Bubble keeps the PC so a later exception can still report a location.
  assign w_bubble = '{pc: D_pc, instr: 32'd0, rs_d: 32'd0, rt_d: 32'd0,
                      imm: 32'd0, gwa: 5'd0, tnew: 2'd0};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_e     <= '{pc: PC_RESET, default: '0};
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else if (w_stall) begin
      r_e     <= w_bubble;
      r_valid <= 1'b0;
      if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
    end else begin
      r_e     <= w_d;
      r_valid <= 1'b1;
    end
  end

  assign stall       = w_stall;
  assign E_pc        = r_e.pc;
  assign E_instr     = r_e.instr;
  assign E_rs_d      = r_e.rs_d;
  assign E_rt_d      = r_e.rt_d;
  assign E_imm       = r_e.imm;
  assign E_gwa       = r_e.gwa;
  assign E_tnew      = r_e.tnew;
  assign E_tnew_next = (r_e.tnew == 2'd0) ? 2'd0 : (r_e.tnew - 2'd1);
  assign E_valid     = r_valid;
  assign bubble_cnt  = r_cnt;

endmodule

// File: tb/tb_e_stage_reg.sv
module tb_e_stage_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] D_pc, D_instr, D_rs_d, D_rt_d, D_imm;
  logic [4:0]  D_rs, D_rt, D_gwa, M_gwa;
  logic [1:0]  D_tnew, D_rs_tuse, D_rt_tuse, M_tnew;
  logic        D_rs_use, D_rt_use, D_is_md, E_md_busy;

  logic        stall, E_valid, stall2, E_valid2;
  logic [31:0] E_pc, E_instr, E_rs_d, E_rt_d, E_imm;
  logic [31:0] E_pc2, E_instr2, E_rs_d2, E_rt_d2, E_imm2;
  logic [4:0]  E_gwa, E_gwa2;
  logic [1:0]  E_tnew, E_tnew_next, E_tnew2, E_tnew_next2;
  logic [15:0] bubble_cnt;
  logic [1:0]  bubble_cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  e_stage_reg dut (
    .clk(clk), .reset(reset), .D_pc(D_pc), .D_instr(D_instr), .D_rs_d(D_rs_d),
    .D_rt_d(D_rt_d), .D_rs(D_rs), .D_rt(D_rt), .D_imm(D_imm), .D_gwa(D_gwa),
    .D_tnew(D_tnew), .D_rs_use(D_rs_use), .D_rs_tuse(D_rs_tuse),
    .D_rt_use(D_rt_use), .D_rt_tuse(D_rt_tuse), .D_is_md(D_is_md),
    .E_md_busy(E_md_busy), .M_gwa(M_gwa), .M_tnew(M_tnew), .stall(stall),
    .E_pc(E_pc), .E_instr(E_instr), .E_rs_d(E_rs_d), .E_rt_d(E_rt_d),
    .E_imm(E_imm), .E_gwa(E_gwa), .E_tnew(E_tnew), .E_tnew_next(E_tnew_next),
    .E_valid(E_valid), .bubble_cnt(bubble_cnt));

  e_stage_reg #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .D_pc(D_pc), .D_instr(D_instr), .D_rs_d(D_rs_d),
    .D_rt_d(D_rt_d), .D_rs(D_rs), .D_rt(D_rt), .D_imm(D_imm), .D_gwa(D_gwa),
    .D_tnew(D_tnew), .D_rs_use(D_rs_use), .D_rs_tuse(D_rs_tuse),
    .D_rt_use(D_rt_use), .D_rt_tuse(D_rt_tuse), .D_is_md(D_is_md),
    .E_md_busy(E_md_busy), .M_gwa(M_gwa), .M_tnew(M_tnew), .stall(stall2),
    .E_pc(E_pc2), .E_instr(E_instr2), .E_rs_d(E_rs_d2), .E_rt_d(E_rt_d2),
    .E_imm(E_imm2), .E_gwa(E_gwa2), .E_tnew(E_tnew2), .E_tnew_next(E_tnew_next2),
    .E_valid(E_valid2), .bubble_cnt(bubble_cnt2));

  // Reference model: what E holds, expressed as plain values.
  typedef struct {
    logic [31:0] pc, instr, rs_d, rt_d, imm;
    logic [4:0]  gwa;
    int          tnew;
    logic        valid;
    int          cnt16, cnt2;
  } model_t;
  model_t m;

  function automatic void model_reset();
    m.pc = 32'h0000_3000; m.instr = 0; m.rs_d = 0; m.rt_d = 0; m.imm = 0;
    m.gwa = 0; m.tnew = 0; m.valid = 0; m.cnt16 = 0; m.cnt2 = 0;
  endfunction

  // A source must wait if a pending producer needs more cycles than the
  // consumer can spare before it reads the value.
  function automatic bit src_waits(bit use_, logic [4:0] idx, int tuse);
    if (!use_ || idx == 0) return 0;
    if (m.gwa == idx && m.tnew > tuse) return 1;
    if (M_gwa == idx && int'(M_tnew) > tuse) return 1;
    return 0;
  endfunction

  function automatic bit exp_stall();
    if (reset !== 1'b1) return 0;
    return src_waits(D_rs_use, D_rs, int'(D_rs_tuse)) ||
           src_waits(D_rt_use, D_rt, int'(D_rt_tuse)) ||
           (D_is_md && E_md_busy);
  endfunction

  function automatic int exp_tnext();
    return (m.tnew > 0) ? m.tnew - 1 : 0;
  endfunction

  // Advance one clock; the model follows the inputs seen just before the edge.
  task automatic tick();
    model_t nx = m;
    if (reset === 1'b1) begin
      if (exp_stall()) begin
        nx.pc = D_pc; nx.instr = 0; nx.rs_d = 0; nx.rt_d = 0; nx.imm = 0;
        nx.gwa = 0; nx.tnew = 0; nx.valid = 0;
        nx.cnt16 = (m.cnt16 < 65535) ? m.cnt16 + 1 : 65535;
        nx.cnt2  = (m.cnt2 < 3) ? m.cnt2 + 1 : 3;
      end else begin
        nx.pc = D_pc; nx.instr = D_instr; nx.rs_d = D_rs_d; nx.rt_d = D_rt_d;
        nx.imm = D_imm; nx.gwa = D_gwa; nx.tnew = int'(D_tnew); nx.valid = 1;
      end
    end
    @(posedge clk);
    m = nx;
    #1;
  endtask

  task automatic idle_inputs();
    D_pc = 32'h0000_3100; D_instr = 32'h0000_0000; D_rs_d = 0; D_rt_d = 0;
    D_imm = 0; D_rs = 0; D_rt = 0; D_gwa = 0; D_tnew = 0;
    D_rs_use = 0; D_rs_tuse = 0; D_rt_use = 0; D_rt_tuse = 0;
    D_is_md = 0; E_md_busy = 0; M_gwa = 0; M_tnew = 0;
  endtask

  task automatic load_instr(logic [31:0] pc, logic [31:0] instr, logic [4:0] gwa, logic [1:0] tnew);
    idle_inputs();
    D_pc = pc; D_instr = instr; D_gwa = gwa; D_tnew = tnew;
    D_rs_d = $urandom; D_rt_d = $urandom; D_imm = $urandom;
    #1;
    tick();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    model_reset();
    D_is_md = 1; E_md_busy = 1;
    #2;
    @(posedge clk); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", stall); end
    checks++; if (E_pc !== 32'h0000_3000) begin errors++; $display("FAIL reset_pc got=%h exp=00003000", E_pc); end
    checks++; if (E_valid !== 1'b0 || E_instr !== 0 || E_gwa !== 0 || E_tnew !== 0)
      begin errors++; $display("FAIL reset_regs valid=%0b instr=%h gwa=%0d tnew=%0d exp all 0", E_valid, E_instr, E_gwa, E_tnew); end
    checks++; if (bubble_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", bubble_cnt); end
    idle_inputs();
    reset = 1'b1;
    #1;
    // first edge after release captures D
    D_instr = 32'h1234_5678; D_pc = 32'h0000_3004;
    #1;
    tick();
    checks++; if (E_valid !== 1'b1 || E_instr !== 32'h1234_5678)
      begin errors++; $display("FAIL reset_release valid=%0b instr=%h exp 1/12345678", E_valid, E_instr); end
  endtask

  task automatic test_load_use();
    load_instr(32'h0000_3010, 32'h8d08_0000, 5'd8, 2'd2); // lw $8
    idle_inputs();
    D_pc = 32'h0000_3014; D_instr = 32'h0108_4821; D_rs = 8; D_rs_use = 1; D_rs_tuse = 1;
    D_gwa = 9; D_tnew = 1; D_rs_d = 32'hAAAA_0001;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL loaduse_stall got=%0b exp=1", stall); end
    tick();
    checks++; if (E_valid !== 1'b0 || E_instr !== 0)
      begin errors++; $display("FAIL loaduse_bubble valid=%0b instr=%h exp 0/0", E_valid, E_instr); end
    checks++; if (bubble_cnt !== 16'(m.cnt16) || m.cnt16 != 1)
      begin errors++; $display("FAIL loaduse_cnt got=%0d exp=1", bubble_cnt); end
    M_gwa = 8; M_tnew = 1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL loaduse_release got=%0b exp=0", stall); end
    tick();
    checks++; if (E_valid !== 1'b1 || E_instr !== 32'h0108_4821 || E_rs_d !== 32'hAAAA_0001)
      begin errors++; $display("FAIL loaduse_capture valid=%0b instr=%h rs_d=%h", E_valid, E_instr, E_rs_d); end
  endtask

  task automatic test_store();
    load_instr(32'h0000_3020, 32'h8d09_0000, 5'd9, 2'd2);
    idle_inputs();
    D_instr = 32'had09_0004; D_rt = 9; D_rt_use = 1; D_rt_tuse = 2; D_rt_d = 32'h5A5A_1234;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL store_stall got=%0b exp=0", stall); end
    tick();
    checks++; if (E_rt_d !== 32'h5A5A_1234 || E_valid !== 1'b1)
      begin errors++; $display("FAIL store_capture rt_d=%h valid=%0b exp 5a5a1234/1", E_rt_d, E_valid); end
  endtask

  task automatic test_zero_reg();
    load_instr(32'h0000_3030, 32'h0000_0001, 5'd0, 2'd2);
    idle_inputs();
    D_rs = 0; D_rs_use = 1; D_rs_tuse = 0; D_rt = 0; D_rt_use = 1; M_gwa = 0; M_tnew = 3;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_reg got=%0b exp=0", stall); end
    tick();
  endtask

  task automatic test_md_busy();
    int c0;
    idle_inputs();
    #1;
    tick();
    c0 = m.cnt16;
    D_is_md = 1; E_md_busy = 1; D_pc = 32'h0000_3040; D_instr = 32'h0109_0018;
    for (int i = 1; i <= 3; i++) begin
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL md_stall%0d got=%0b exp=1", i, stall); end
      tick();
      checks++; if (E_pc !== 32'h0000_3040 || E_valid !== 1'b0 || bubble_cnt !== 16'(c0 + i))
        begin errors++; $display("FAIL md_bubble%0d pc=%h valid=%0b cnt=%0d exp cnt=%0d", i, E_pc, E_valid, bubble_cnt, c0 + i); end
    end
    E_md_busy = 0;
    #1;
    tick();
    checks++; if (E_valid !== 1'b1 || E_instr !== 32'h0109_0018)
      begin errors++; $display("FAIL md_capture valid=%0b instr=%h", E_valid, E_instr); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      D_pc = $urandom; D_instr = $urandom; D_rs_d = $urandom; D_rt_d = $urandom; D_imm = $urandom;
      D_rs = ($urandom_range(0, 2) == 0) ? m.gwa : 5'($urandom_range(0, 7));
      D_rt = ($urandom_range(0, 2) == 0) ? m.gwa : 5'($urandom_range(0, 7));
      D_gwa = 5'($urandom_range(0, 7)); D_tnew = 2'($urandom);
      D_rs_use = 1'($urandom); D_rt_use = 1'($urandom);
      D_rs_tuse = 2'($urandom); D_rt_tuse = 2'($urandom);
      D_is_md = ($urandom_range(0, 4) == 0); E_md_busy = ($urandom_range(0, 2) == 0);
      M_gwa = 5'($urandom_range(0, 7)); M_tnew = 2'($urandom);
      #1;
      checks++; if (stall !== exp_stall()) begin errors++; $display("FAIL rnd_stall n=%0d got=%0b exp=%0b", n, stall, exp_stall()); end
      tick();
      checks++;
      if (E_pc !== m.pc || E_instr !== m.instr || E_rs_d !== m.rs_d || E_rt_d !== m.rt_d ||
          E_imm !== m.imm || E_gwa !== m.gwa || E_tnew !== 2'(m.tnew) || E_valid !== m.valid) begin
        errors++;
        $display("FAIL rnd_regs n=%0d pc=%h/%h instr=%h/%h gwa=%0d/%0d tnew=%0d/%0d valid=%0b/%0b",
                 n, E_pc, m.pc, E_instr, m.instr, E_gwa, m.gwa, E_tnew, m.tnew, E_valid, m.valid);
      end
      checks++; if (E_tnew_next !== 2'(exp_tnext()))
        begin errors++; $display("FAIL rnd_tnext n=%0d got=%0d exp=%0d", n, E_tnew_next, exp_tnext()); end
      checks++; if (bubble_cnt !== 16'(m.cnt16) || bubble_cnt2 !== 2'(m.cnt2))
        begin errors++; $display("FAIL rnd_cnt n=%0d got=%0d/%0d exp=%0d/%0d", n, bubble_cnt, bubble_cnt2, m.cnt16, m.cnt2); end
    end
  endtask

  task automatic test_async_reset();
    load_instr(32'h0000_3050, 32'hDEAD_BEEF, 5'd4, 2'd1);
    checks++; if (E_valid !== 1'b1) begin errors++; $display("FAIL areset_pre valid=%0b exp=1", E_valid); end
    #3;
    reset = 1'b0;
    #1;
    checks++; if (E_pc !== 32'h0000_3000 || E_instr !== 0 || E_valid !== 1'b0 || E_gwa !== 0 || bubble_cnt !== 0)
      begin errors++; $display("FAIL areset_clear pc=%h instr=%h valid=%0b gwa=%0d cnt=%0d", E_pc, E_instr, E_valid, E_gwa, bubble_cnt); end
    model_reset();
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
  endtask

  task automatic test_saturation();
    int exp_seq[5] = '{1, 2, 3, 3, 3};
    do_reset();
    D_is_md = 1; E_md_busy = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      tick();
      checks++; if (bubble_cnt2 !== 2'(exp_seq[i]))
        begin errors++; $display("FAIL sat_cnt%0d got=%0d exp=%0d", i, bubble_cnt2, exp_seq[i]); end
    end
    checks++; if (bubble_cnt !== 16'd5) begin errors++; $display("FAIL sat_wide got=%0d exp=5", bubble_cnt); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    model_reset();
    #2;
    test_reset();
    test_load_use();
    test_store();
    test_zero_reg();
    test_md_busy();
    test_async_reset();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/e_stage_reg.md
Name: e_stage_reg

Overview:
- D/E pipeline register with built-in stall detection for the five-stage MIPS pipeline.
- Captures operands read by the D-stage register file plus decode results, and presents them to the E stage.
- Detects Tuse/Tnew data hazards against the instructions currently in E and M, and detects busy multiply/divide conflicts.
- On a hazard it asserts stall (freezing PC and F/D) and inserts a bubble into E. It also keeps a saturating bubble counter.

Parameters:
- PC_RESET, 32'h0000_3000, E_pc value after reset.
- CNT_W, 16, width of the bubble performance counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- D_pc  input  32  PC of the instruction in D.
- D_instr  input  32  instruction word in D.
- D_rs_d  input  32  rs operand from the register file, already internally forwarded.
- D_rt_d  input  32  rt operand from the register file.
- D_rs  input  5  rs index.
- D_rt  input  5  rt index.
- D_imm  input  32  extended immediate.
- D_gwa  input  5  destination register; 0 means no write.
- D_tnew  input  2  cycles after entering E until the result is ready.
- D_rs_use  input  1  instruction reads rs.
- D_rs_tuse  input  2  cycles from D until rs is needed.
- D_rt_use  input  1  instruction reads rt.
- D_rt_tuse  input  2  cycles from D until rt is needed.
- D_is_md  input  1  instruction is mult/div/mfhi/mflo/mthi/mtlo.
- E_md_busy  input  1  multiply/divide unit busy, or starting this cycle.
- M_gwa  input  5  destination of the instruction in M.
- M_tnew  input  2  remaining Tnew of the instruction in M.
- stall  output  1  freeze PC and F/D, and bubble E.
- E_pc  output  32  registered PC.
- E_instr  output  32  registered instruction.
- E_rs_d  output  32  registered rs operand.
- E_rt_d  output  32  registered rt operand.
- E_imm  output  32  registered immediate.
- E_gwa  output  5  registered destination.
- E_tnew  output  2  registered Tnew.
- E_tnew_next  output  2  value handed to M: max(E_tnew-1, 0).
- E_valid  output  1  E holds a real instruction, not a bubble.
- bubble_cnt  output  CNT_W  number of bubbles inserted since reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - E_pc=PC_RESET.
  - All other registered outputs =0.
  - E_valid=0, bubble_cnt=0.
  - Takes effect immediately and overrides any in-flight capture.
- stall is combinational and equals stall_rs | stall_rt | stall_md.
  - stall_rs = D_rs_use & (D_rs!=0) & ((E_gwa==D_rs & E_tnew>D_rs_tuse) | (M_gwa==D_rs & M_tnew>D_rs_tuse)).
  - stall_rt is the same expression using the rt signals.
  - stall_md = D_is_md & E_md_busy.
  - When stall=0, any match in E or M is handled by downstream forwarding.
  - During reset, stall is driven 0.
- Each rising edge with stall=0: all E_* registers load the corresponding D_* values, and E_valid<=1.
- Each rising edge with stall=1 (bubble):
  - E_instr<=0, E_gwa<=0, E_tnew<=0, E_rs_d<=0, E_rt_d<=0, E_imm<=0, E_valid<=0.
  - E_pc<=D_pc, retained for later exception reporting.
  - bubble_cnt increments by 1 and saturates at all-ones.
- E_tnew_next is combinational: E_tnew==0 gives 0, otherwise E_tnew-1. A bubble therefore always hands 0 to M.
- Latency: one cycle from D to E. There is no hold mode; E always advances.
- Simultaneous hazards: stall is a single OR of all sources, and only one bubble is inserted per cycle.
- Repeated stall cycles insert one bubble per cycle. The D inputs are held stable by the upstream freeze.
- Index 0 never causes a stall, even if E_gwa or M_gwa equals 0.
- Reset deasserted mid-stream: the first edge after release captures D normally, provided stall=0.

Test Plan:
- Load-use, no hazard in M:
  - Stimulus: E holds lw with E_gwa=8, E_tnew=2. D presents addu with rs=8, rs_tuse=1, rs_use=1.
  - Required: stall=1, next edge E_valid=0, E_instr=0, bubble_cnt=1.
  - Next cycle, with E_gwa=0 and M_gwa=8, M_tnew=1: stall=0 and addu captured.
- Store data, no stall:
  - Stimulus: D sw with rt=9, rt_tuse=2. E holds lw with E_gwa=9, E_tnew=2.
  - Required: stall=0, and sw is captured with E_rt_d=D_rt_d.
- Register $0:
  - Stimulus: D_rs=0, E_gwa=0, E_tnew=2.
  - Required: stall=0.
- Multiply/divide busy:
  - Stimulus: D_is_md=1 and E_md_busy=1 for 3 cycles.
  - Required: 3 bubbles, bubble_cnt=3, E_pc=D_pc each bubble. The instruction is captured on the cycle E_md_busy drops.
- Asynchronous reset:
  - Stimulus: reset=0 mid-cycle while E is valid.
  - Required: outputs clear at once without a clock edge; E_pc=32'h0000_3000.
- Counter saturation:
  - Stimulus: CNT_W=2, 5 consecutive stalls.
  - Required: bubble_cnt reads 1, 2, 3, 3, 3.
